// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, constants and note table for the sound-effect sequencer
package sfx_pkg;

  localparam int SFX_NUM_EFFECTS = 4;
  localparam int SFX_MAX_NOTES   = 8;
  localparam int SFX_DIV_W       = 17;
  localparam int SFX_DUR_W       = 24;
  localparam int SFX_EFF_W       = $clog2(SFX_NUM_EFFECTS);
  localparam int SFX_IDX_W       = $clog2(SFX_MAX_NOTES);

  localparam logic [SFX_EFF_W-1:0] SFX_JUMP   = 2'd0;
  localparam logic [SFX_EFF_W-1:0] SFX_SQUASH = 2'd1;
  localparam logic [SFX_EFF_W-1:0] SFX_SPLASH = 2'd2;
  localparam logic [SFX_EFF_W-1:0] SFX_HOME   = 2'd3;

  typedef struct packed {
    logic [SFX_DIV_W-1:0] half_period;
    logic [SFX_DUR_W-1:0] duration;
    logic                 last;
  } note_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} sfx_state_e;

  function automatic note_t mk(input int hp, input int dur, input logic fin);
    mk = '{half_period: SFX_DIV_W'(hp), duration: SFX_DUR_W'(dur), last: fin};
  endfunction

  // half_period 0 is a rest; HOME relies on the forced last at the final slot
  function automatic note_t sfx_note_lookup(input logic [SFX_EFF_W-1:0] effect,
                                            input logic [SFX_IDX_W-1:0] idx);
    note_t n;
    n = '0;
    case (effect)
      SFX_JUMP: case (idx)
        3'd0:    n = mk(14261, 6_250_000, 1'b0);
        3'd1:    n = mk(9514, 6_250_000, 1'b1);
        default: n = '0;
      endcase
      SFX_SQUASH: case (idx)
        3'd0:    n = mk(20000, 3_000_000, 1'b0);
        3'd1:    n = mk(0, 1_000_000, 1'b0);
        3'd2:    n = mk(25000, 3_000_000, 1'b1);
        default: n = '0;
      endcase
      SFX_SPLASH: case (idx)
        3'd0:    n = mk(500, 1_000_000, 1'b0);
        3'd1:    n = mk(300, 1_000_000, 1'b0);
        3'd2:    n = mk(0, 500_000, 1'b0);
        3'd3:    n = mk(200, 1_000_000, 1'b1);
        default: n = '0;
      endcase
      default: n = mk(12000 - 1000 * int'(idx), 1_000_000, 1'b0);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// rtl/sfx_note_rom.sv - combinational (effect, note index) to note entry lookup
module sfx_note_rom
  import sfx_pkg::*;
(
  input  logic [SFX_EFF_W-1:0] effect,
  input  logic [SFX_IDX_W-1:0] note_idx,
  output note_t                note
);

  assign note = sfx_note_lookup(effect, note_idx);

endmodule

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - multi-effect square-wave sound sequencer with priority pre-emption
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int NUM_EFFECTS = SFX_NUM_EFFECTS,
  parameter int MAX_NOTES   = SFX_MAX_NOTES,
  parameter int DIV_W       = SFX_DIV_W,
  parameter int DUR_W       = SFX_DUR_W,
  parameter int GAP_CYCLES  = 250000,
  parameter int DUR_SHIFT   = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_EFFECTS-1:0]         trig_i,
  input  logic                           mute_i,
  output logic                           sound_o,
  output logic                           busy_o,
  output logic [$clog2(NUM_EFFECTS)-1:0] active_o,
  output logic                           done_o
);

  localparam int EFF_W   = $clog2(NUM_EFFECTS);
  localparam int IDX_W   = $clog2(MAX_NOTES);
  localparam int GAP_LEN = GAP_CYCLES >> DUR_SHIFT;
  localparam logic [DUR_W-1:0] GAP_END = (GAP_LEN > 0) ? DUR_W'(GAP_LEN - 1) : '0;

  sfx_state_e             state;
  logic [NUM_EFFECTS-1:0] trig_q;
  logic                   armed, tone, cur_last;
  logic [IDX_W-1:0]       note_idx;
  logic [DIV_W-1:0]       half_cnt, cur_hp;
  logic [DUR_W-1:0]       dur_cnt, cur_end;

  logic [NUM_EFFECTS-1:0] edges;
  logic [EFF_W-1:0]       win, ld_eff;
  logic [IDX_W-1:0]       ld_idx;
  logic                   has_edge, accept, note_end, gap_end, toggle;
  logic                   ld_last, start_note, tone_n;
  logic [DIV_W-1:0]       ld_hp;
  logic [DUR_W-1:0]       ld_lim, ld_end;
  note_t                  ld_note;

  // The ROM is addressed by whichever note starts next; its fields are latched at note start
  sfx_note_rom u_rom (
    .effect   (SFX_EFF_W'(ld_eff)),
    .note_idx (SFX_IDX_W'(ld_idx)),
    .note     (ld_note)
  );

  always_comb begin
    // armed masks the first cycle after reset so a held trigger is not seen as an edge
    edges    = armed ? (trig_i & ~trig_q) : '0;
    win      = '0;
    has_edge = 1'b0;
    for (int i = 0; i < NUM_EFFECTS; i++) begin
      if (edges[i]) begin
        win      = EFF_W'(i);
        has_edge = 1'b1;
      end
    end
    accept     = has_edge && (state == IDLE || win >= active_o);
    ld_eff     = accept ? win : active_o;
    ld_idx     = accept ? '0 : note_idx + 1'b1;
    ld_hp      = DIV_W'(ld_note.half_period);
    ld_lim     = DUR_W'(ld_note.duration) >> DUR_SHIFT;
    ld_end     = (ld_lim == '0) ? '0 : ld_lim - 1'b1;
    ld_last    = ld_note.last || (ld_idx == IDX_W'(MAX_NOTES - 1));
    note_end   = (state == PLAY) && (dur_cnt == cur_end);
    gap_end    = (state == GAP) && (dur_cnt == GAP_END);
    toggle     = (state == PLAY) && (cur_hp != '0) && (half_cnt == cur_hp - 1'b1);
    start_note = accept || gap_end || (note_end && !cur_last && GAP_LEN == 0);
    tone_n     = tone;
    if (start_note)                     tone_n = (ld_hp != '0);
    else if (note_end || state != PLAY) tone_n = 1'b0;
    else if (toggle)                    tone_n = ~tone;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      trig_q   <= '0;
      armed    <= 1'b0;
      tone     <= 1'b0;
      note_idx <= '0;
      half_cnt <= '0;
      dur_cnt  <= '0;
      cur_hp   <= '0;
      cur_end  <= '0;
      cur_last <= 1'b0;
      sound_o  <= 1'b0;
      busy_o   <= 1'b0;
      active_o <= '0;
      done_o   <= 1'b0;
    end else begin
      trig_q  <= trig_i;
      armed   <= 1'b1;
      done_o  <= 1'b0;
      tone    <= tone_n;
      sound_o <= tone_n & ~mute_i;
      if (start_note) begin
        state    <= PLAY;
        busy_o   <= 1'b1;
        active_o <= ld_eff;
        note_idx <= ld_idx;
        half_cnt <= '0;
        dur_cnt  <= '0;
        cur_hp   <= ld_hp;
        cur_end  <= ld_end;
        cur_last <= ld_last;
      end else begin
        case (state)
          PLAY: begin
            if (note_end) begin
              half_cnt <= '0;
              dur_cnt  <= '0;
              if (cur_last) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              dur_cnt  <= dur_cnt + 1'b1;
              half_cnt <= toggle ? '0 : half_cnt + 1'b1;
            end
          end
          GAP:     dur_cnt <= dur_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb/tb_sfx_sequencer.sv - directed self-checking bench for sfx_sequencer
module tb_sfx_sequencer;

  logic       clk;
  logic       reset_n;
  logic [3:0] trig_i;
  logic       mute_i;
  logic       sound_o;
  logic       busy_o;
  logic [1:0] active_o;
  logic       done_o;

  int n_checks, n_errors;
  int hi_acc, busy_acc, done_acc;

  sfx_sequencer #(.DUR_SHIFT(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .trig_i   (trig_i),
    .mute_i   (mute_i),
    .sound_o  (sound_o),
    .busy_o   (busy_o),
    .active_o (active_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    hi_acc   += int'(sound_o);
    busy_acc += int'(busy_o);
    done_acc += int'(done_o);
  endtask

  task automatic clear_acc();
    hi_acc   = 0;
    busy_acc = 0;
    done_acc = 0;
  endtask

  // Jump: 6103-cycle note, 244-cycle gap, 6103-cycle note; half periods exceed the note length
  task automatic jump_run(input logic m);
    mute_i = m;
    clear_acc();
    trig_i = 4'b0001;
    tick();
    chk("jump_start_busy", busy_o, 1);
    chk("jump_start_sound", sound_o, {31'd0, !m});
    chk("jump_start_active", active_o, 0);
    trig_i = 4'b0000;
    repeat (6102) tick();
    chk("jump_n1_hi", hi_acc, m ? 0 : 6103);
    tick();
    chk("jump_gap_sound", sound_o, 0);
    chk("jump_gap_busy", busy_o, 1);
    repeat (243) tick();
    chk("jump_gap_hi", hi_acc, m ? 0 : 6103);
    tick();
    chk("jump_n2_sound", sound_o, {31'd0, !m});
    repeat (6102) tick();
    chk("jump_end_busy", busy_o, 1);
    chk("jump_total_hi", hi_acc, m ? 0 : 12206);
    chk("jump_total_busy", busy_acc, 12450);
    chk("jump_no_early_done", done_acc, 0);
    tick();
    chk("jump_done", done_o, 1);
    chk("jump_idle_busy", busy_o, 0);
    chk("jump_idle_sound", sound_o, 0);
    tick();
    chk("jump_done_once", done_acc, 1);
    mute_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_acc();
    reset_n = 1'b0;
    trig_i  = 4'b0000;
    mute_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sound", sound_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_active", active_o, 0);
    chk("reset_done", done_o, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    jump_run(1'b0);
    jump_run(1'b1);

    // Simultaneous edges on 0 and 2: splash wins; splash hi cycles 500+600+0+576
    clear_acc();
    trig_i = 4'b0101;
    tick();
    chk("simul_active", active_o, 2);
    chk("simul_sound", sound_o, 1);
    trig_i = 4'b0000;
    repeat (4147) tick();
    chk("simul_hi", hi_acc, 1676);
    chk("simul_busy_cnt", busy_acc, 4148);
    tick();
    chk("simul_done", done_o, 1);
    tick();

    // Squash pre-empted by splash; a later jump edge is dropped
    trig_i = 4'b0010;
    tick();
    chk("squash_active", active_o, 1);
    trig_i = 4'b0000;
    repeat (999) tick();
    chk("squash_mid_sound", sound_o, 1);
    clear_acc();
    trig_i = 4'b0100;
    tick();
    chk("pre_active", active_o, 2);
    chk("pre_done", done_o, 0);
    trig_i = 4'b0000;
    repeat (499) tick();
    chk("pre_half_hi", sound_o, 1);
    tick();
    chk("pre_half_toggle", sound_o, 0);
    repeat (99) tick();
    trig_i = 4'b0001;
    tick();
    chk("drop_active", active_o, 2);
    trig_i = 4'b0000;
    repeat (3547) tick();
    chk("pre_hi", hi_acc, 1676);
    chk("pre_no_done", done_acc, 0);
    tick();
    chk("pre_done_end", done_o, 1);
    tick();
    chk("drop_not_queued", busy_o, 0);

    // Home has no table last flag: ends after slot 7 (8 x 976 + 7 x 244 cycles)
    clear_acc();
    trig_i = 4'b1000;
    tick();
    trig_i = 4'b0000;
    repeat (9515) tick();
    chk("home_busy", busy_o, 1);
    chk("home_hi", hi_acc, 7808);
    tick();
    chk("home_done", done_o, 1);
    tick();

    // Reset mid-note with trigger held high
    trig_i = 4'b0001;
    tick();
    repeat (100) tick();
    chk("rst_pre_sound", sound_o, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_sound", sound_o, 0);
    chk("rst_busy", busy_o, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    clear_acc();
    repeat (20) tick();
    chk("rst_held_idle", busy_acc, 0);

    // Retrigger jump on its final completion cycle
    trig_i = 4'b0000;
    tick();
    clear_acc();
    trig_i = 4'b0001;
    tick();
    chk("rt_start_busy", busy_o, 1);
    trig_i = 4'b0000;
    repeat (12449) tick();
    trig_i = 4'b0001;
    tick();
    chk("rt_busy", busy_o, 1);
    chk("rt_done", done_o, 0);
    chk("rt_sound", sound_o, 1);
    trig_i = 4'b0000;
    repeat (6102) tick();
    chk("rt_n0_sound", sound_o, 1);
    tick();
    chk("rt_n0_gap", sound_o, 0);
    chk("rt_no_done", done_acc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Multi-effect square-wave sound player; successor to the single-tone jump beeper.
- Holds NUM_EFFECTS short note sequences (jump, squash, splash, home) in a constant note table.
- A rising edge on a trigger bit plays that effect note by note, with rests, inter-note gaps, priority pre-emption and mute.
- Sits between game-state logic and the 1-bit audio pin driver; clocked by the 25.1 MHz pixel clock.

Parameters:
- NUM_EFFECTS, 4, number of effects / trigger bits
- MAX_NOTES, 8, note slots per effect
- DIV_W, 17, width of half-period counter
- DUR_W, 24, width of note-duration counter
- GAP_CYCLES, 250000, silent cycles between consecutive notes (0 = no gap)
- DUR_SHIFT, 0, right-shift applied to table durations and GAP_CYCLES (benches set 10 for speed)

Ports:
- clk  in  1  system clock, 25.1 MHz
- reset_n  in  1  asynchronous active-low reset
- trig_i  in  NUM_EFFECTS  level triggers; rising edge starts an effect
- mute_i  in  1  forces sound_o low; sequencing continues
- sound_o  out  1  square-wave audio
- busy_o  out  1  high while an effect plays
- active_o  out  $clog2(NUM_EFFECTS)  index of the playing effect
- done_o  out  1  one-cycle pulse when an effect completes naturally

Behaviour:
- Reset, asynchronous active-low: all registers clear.
  - Outputs: sound_o=0, busy_o=0, active_o=0, done_o=0.
  - State: state=IDLE, trigger history=0.
- Edge detect: edge = trig_i & ~trig_q. trig_q is registered every cycle.
- Winner: the highest-index set edge bit.
  - Accepted in IDLE always.
  - In PLAY or GAP, accepted only if winner index >= active_o (pre-empt/retrigger). Lower-priority edges are dropped, not queued.
- Accepted edge in cycle N: at the end of N:
  - State updates: state=PLAY, active_o=winner, note_idx=0, half_cnt=0, dur_cnt=0.
  - Status: busy_o=1.
  - Tone: tone level = 1 (0 if the note is a rest).
  - First tone cycle is N+1.
- Note entry: half_period (DIV_W), duration (DUR_W), last flag.
  - half_period=0 means rest; tone level is held at 0.
- PLAY:
  - half_cnt increments each cycle. At half_cnt==half_period-1, it wraps to 0 and the tone level toggles.
  - dur_cnt increments each cycle. At dur_cnt==(duration>>DUR_SHIFT)-1, the note ends.
- Note end:
  - last=1: go to IDLE with busy_o=0 and tone=0. done_o=1 for exactly the following cycle.
  - last=0 and GAP_CYCLES>>DUR_SHIFT > 0: go to GAP with tone=0.
  - Otherwise: go directly to PLAY with note_idx+1, counters cleared, tone=1 (or 0 for a rest).
- GAP: counts (GAP_CYCLES>>DUR_SHIFT) cycles, then enters PLAY on note_idx+1 with counters cleared.
- note_idx reaching MAX_NOTES-1 forces last regardless of the table flag.
- Duration 0 in the table is treated as 1.
- sound_o is registered: tone & ~mute_i & busy. Mute takes effect one cycle after mute_i changes.
- Pre-emption: done_o is not pulsed for the aborted effect.
- An edge and a natural completion in the same cycle: the edge wins. State goes to PLAY, busy_o stays 1, done_o stays 0.
- Reset asserted mid-effect: immediate silence. After release, the block stays idle until a new edge; a trigger held high through reset release does not start an effect.

Decomposition:
- sfx_pkg holds:
  - note_t struct {half_period, duration, last}.
  - Effect index constants: SFX_JUMP=0, SFX_SQUASH=1, SFX_SPLASH=2, SFX_HOME=3.
  - The constant note table, including JUMP = {14261 half-period for 6_250_000 cycles, 9514 for 6_250_000 cycles, last}.
  - The state enum {IDLE, PLAY, GAP}.
- One sub-module: sfx_note_rom. It is a combinational lookup (effect, note_idx) -> note_t from the package table.

Test Plan:
- Reset, then pulse trig_i[0] with DUR_SHIFT=10:
  - sound_o rises the cycle after the edge and toggles every 14261 cycles for 6103 cycles.
  - It is then low for 244 gap cycles, then toggles every 9514 cycles for 6103 cycles.
  - done_o pulses once; busy_o falls.
- Raise trig_i[0] and trig_i[2] in the same cycle -> active_o=2, effect 2 sequence plays, effect 0 is ignored.
- Trigger effect 2 mid-play of effect 1, then trigger effect 0 mid-play of effect 2:
  - Effect 2 pre-empts effect 1 with counters restarted; no done_o for effect 1.
  - The effect 0 edge is dropped; effect 2 runs to completion.
- Hold mute_i=1 during a jump -> sound_o stays 0, busy_o and done_o timing are identical to the unmuted run.
- Assert reset_n low mid-note with trig_i[0] held high, then release -> sound_o=0 and busy_o=0 immediately; no playback until trig_i[0] falls and rises again.
- Retrigger effect 0 on its last-note completion cycle -> done_o stays 0, busy_o stays 1, playback restarts at note 0.
